// File: rtl/data_mem_ws.sv
// data_mem_ws: byte-enabled word memory behind a req/ready request port and a
// valid/ready response port, with WAIT_CYCLES wait states per access.
// Optional feature: define DATA_MEM_WS_ERR_EN to flag misaligned accesses
// (err=1, write suppressed, rdata=0). Without it, low address bits are ignored.
module data_mem_ws #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);

  localparam int unsigned BeW      = DATA_W / 8;
  localparam int unsigned OffW     = $clog2(BeW);
  localparam int unsigned Depth    = (1 << ADDR_W) / BeW;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [DATA_W-1:0]      mem_q [Depth];
  logic [ADDR_W-OffW-1:0] word_idx;
  logic                   misaligned;
  logic                   accept;
  logic                   do_write;

  assign word_idx = addr[ADDR_W-1:OffW];

`ifdef DATA_MEM_WS_ERR_EN
  if (OffW > 0) begin : g_off
    assign misaligned = |addr[OffW-1:0];
  end else begin : g_no_off
    assign misaligned = 1'b0;
  end
`else
  logic addr_unused;
  assign addr_unused = ^addr;
  assign misaligned  = 1'b0;
`endif

  // Reset takes priority so nothing commits while rst_n is low.
  assign accept   = req && (state_q == StIdle) && rst_n;
  assign do_write = accept && we && !misaligned;

  // Next-state: capture response on acceptance, count wait states, hold until consumed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          err_d   = misaligned;
          rdata_d = (we || misaligned) ? '0 : mem_q[word_idx];
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        // Leave on the edge where the counter reaches zero.
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
          cnt_d   = '0;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array, never reset; byte lanes written under be.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BeW; i++) begin
      if (do_write && be[i]) mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign ready      = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign rdata      = rdata_q;
  assign err        = err_q;

endmodule

// File: doc/data_mem_ws.md
DATA_MEM_WS -- requirements
Module: data_mem_ws

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named clk and rst_n.
REQ-002 The block SHALL have parameter DATA_W, default 32, word width in bits (multiple of 8, min 8).
REQ-003 The block SHALL have parameter ADDR_W, default 9, byte-address width; DEPTH = 2^ADDR_W / (DATA_W/8) words (default 128).
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 0, range 0..15: extra wait states per access.
REQ-005 The block SHALL have the following ports:
  clk         in   1         rising-edge clock
  rst_n       in   1         synchronous active-low reset
  req         in   1         access request
  we          in   1         1 = write, 0 = read
  addr        in   ADDR_W    byte address; word index = addr[ADDR_W-1:log2(DATA_W/8)]
  wdata       in   DATA_W    write data
  be          in   DATA_W/8  byte enables for writes
  ready       out  1         request accepted when req && ready
  resp_valid  out  1         response present
  resp_ready  in   1         response consumed when resp_valid && resp_ready
  rdata       out  DATA_W    read data, valid with resp_valid on reads
  err         out  1         access error, valid with resp_valid

Function
REQ-006 The controller SHALL use a three-state machine: IDLE, WAIT, RESP.
REQ-007 ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-008 Acceptance SHALL occur on the rising edge where req && ready; we/addr/wdata/be SHALL be ignored at all other times.
REQ-009 On acceptance, if WAIT_CYCLES == 0 the state SHALL go IDLE->RESP; otherwise IDLE->WAIT, with the counter loaded to WAIT_CYCLES.
REQ-010 In WAIT the counter SHALL decrement each cycle and move WAIT->RESP on the edge where it reaches 0 (exactly WAIT_CYCLES cycles spent in WAIT).
REQ-011 Response latency SHALL be WAIT_CYCLES+1 cycles from the acceptance edge to the first cycle of resp_valid.
REQ-012 In RESP the state SHALL hold with rdata/err stable until resp_ready=1, then move RESP->IDLE on that edge; the next request can be accepted one cycle later.
REQ-013 A write SHALL commit on the acceptance edge, updating only bytes i where be[i]=1; be=0 SHALL produce a normal response with no memory change.
REQ-014 A read SHALL capture the addressed word into the rdata register on the acceptance edge; rdata SHALL be 0 for write responses.
REQ-015 A read accepted after a write to the same word SHALL return the merged written data.
REQ-016 Memory contents SHALL NOT be reset; rdata, err and resp_valid SHALL hold their values outside RESP only as defined by reset and REQ-014.

Reset
REQ-017 While rst_n=0 at a rising edge, the state SHALL go to IDLE, the counter to 0, and resp_valid, rdata and err to 0; ready SHALL be 1 in the cycle after reset.
REQ-018 Reset asserted in WAIT or RESP SHALL abort the pending response with no resp_valid emitted; a write already committed SHALL remain in memory.

Configuration
REQ-019 Macro DATA_MEM_WS_ERR_EN SHALL control error detection.
REQ-020 With DATA_MEM_WS_ERR_EN defined, an accepted access with nonzero addr[log2(DATA_W/8)-1:0] SHALL set err=1 in its response, suppress the write and return rdata=0.
REQ-021 Without DATA_MEM_WS_ERR_EN, low address bits SHALL be ignored and err SHALL be constant 0.

Verification
REQ-022 Defaults, reset, write addr=0x08 wdata=0xDEADBEEF be=0xF, then read 0x08 -> resp_valid 1 cycle after acceptance, rdata=0xDEADBEEF, err=0.
REQ-023 Word at 0x08 = 0xDEADBEEF; write 0x08 wdata=0x11223344 be=0b0101; read 0x08 -> rdata=0xDE22BE44.
REQ-024 WAIT_CYCLES=3; read -> ready=0 for 4 cycles; resp_valid rises exactly 4 cycles after acceptance; resp_ready held 0 for 5 cycles -> rdata stable, ready stays 0.
REQ-025 WAIT_CYCLES=3; rst_n=0 for one edge during WAIT -> no resp_valid; ready=1 in the following cycle; an earlier committed write is still readable.
REQ-026 DATA_MEM_WS_ERR_EN defined; write 0x0A wdata=0xFFFFFFFF -> err=1; read 0x08 -> old value unchanged, err=0.
REQ-027 req held 1 continuously with resp_ready=1 -> exactly one acceptance per WAIT_CYCLES+2 cycles, with responses in order.
